// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl: 6502 bus decoder with per-region read wait states and open-bus reads,
// plus synchronised IRQ aggregation and pulse-stretched, queued NMI generation.
module cpu_bus_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int N_REGIONS = 4,
    parameter int WAIT_W    = 3,
    parameter int N_IRQ     = 4,
    parameter int N_NMI     = 2,
    parameter int NMI_PULSE = 2
) (
    input  logic                          clk_clk_i,
    input  logic                          rst_rst_n_i,
    input  logic [ADDR_W-1:0]             cpu_a_i,
    input  logic [DATA_W-1:0]             cpu_d_i,
    input  logic                          cpu_rd_i,
    input  logic                          cpu_wr_i,
    output logic [DATA_W-1:0]             cpu_d_o,
    output logic                          cpu_rdy_o,
    input  logic [N_REGIONS*ADDR_W-1:0]   region_base_i,
    input  logic [N_REGIONS*ADDR_W-1:0]   region_mask_i,
    input  logic [N_REGIONS*WAIT_W-1:0]   region_wait_i,
    output logic [N_REGIONS-1:0]          bus_sel_o,
    output logic [ADDR_W-1:0]             bus_a_o,
    output logic [DATA_W-1:0]             bus_d_o,
    output logic                          bus_rd_o,
    output logic                          bus_wr_o,
    input  logic [N_REGIONS*DATA_W-1:0]   bus_d_i,
    input  logic [N_IRQ-1:0]              irq_src_i,
    input  logic [N_IRQ-1:0]              irq_en_i,
    input  logic [N_NMI-1:0]              nmi_src_i,
    output logic                          irq_n_o,
    output logic                          nmi_n_o,
    output logic [N_IRQ-1:0]              irq_pending_o
);
    localparam int PW = $clog2(NMI_PULSE + 1);
    typedef enum logic {ST_IDLE, ST_WAIT} state_t;
    state_t               state;
    logic [WAIT_W-1:0]    cnt, wait_sel;
    logic [N_REGIONS-1:0] sel;
    logic                 hit, start, rdy;
    logic [DATA_W-1:0]    rdata, open_bus;
    logic [N_IRQ-1:0]     irq_s1, irq_s2;
    logic [N_NMI-1:0]     nmi_s1, nmi_s2, nmi_s3;
    logic                 nmi_edge, nmi_pend;
    logic [PW-1:0]        pcnt;

    // descending scan: the lowest matching region is written last and wins
    always_comb begin
        sel      = '0;
        hit      = 1'b0;
        wait_sel = '0;
        rdata    = '0;
        for (int k = N_REGIONS - 1; k >= 0; k--)
            if (((cpu_a_i ^ region_base_i[k*ADDR_W +: ADDR_W]) & region_mask_i[k*ADDR_W +: ADDR_W]) == '0) begin
                sel      = N_REGIONS'(1) << k;
                hit      = 1'b1;
                wait_sel = region_wait_i[k*WAIT_W +: WAIT_W];
                rdata    = bus_d_i[k*DATA_W +: DATA_W];
            end
    end

    assign bus_sel_o     = sel;
    assign bus_a_o       = cpu_a_i;
    assign bus_d_o       = cpu_d_i;
    assign bus_rd_o      = cpu_rd_i & hit;
    assign bus_wr_o      = cpu_wr_i & hit;
    assign cpu_d_o       = hit ? rdata : open_bus;
    assign start         = cpu_rd_i && hit && (wait_sel != '0);
    assign rdy           = (state == ST_IDLE) ? !start : (!cpu_rd_i || cnt == '0);
    // reset must release a stalled core without waiting for a clock edge
    assign cpu_rdy_o     = !rst_rst_n_i || rdy;
    assign irq_pending_o = irq_s2 & irq_en_i;
    assign nmi_edge      = |(nmi_s2 & ~nmi_s3);

    always_ff @(posedge clk_clk_i or negedge rst_rst_n_i) begin
        if (!rst_rst_n_i) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            open_bus <= '0;
        end else begin
            if (cpu_rd_i && hit && rdy)
                open_bus <= rdata;
            if (state == ST_IDLE) begin
                if (start) begin
                    state <= ST_WAIT;
                    cnt   <= wait_sel - WAIT_W'(1);
                end
            end else if (!cpu_rd_i || cnt == '0)
                state <= ST_IDLE;
            else
                cnt <= cnt - WAIT_W'(1);
        end
    end

    always_ff @(posedge clk_clk_i or negedge rst_rst_n_i) begin
        if (!rst_rst_n_i) begin
            irq_s1   <= '0;
            irq_s2   <= '0;
            irq_n_o  <= 1'b1;
            nmi_s1   <= '0;
            nmi_s2   <= '0;
            nmi_s3   <= '0;
            nmi_n_o  <= 1'b1;
            nmi_pend <= 1'b0;
            pcnt     <= '0;
        end else begin
            irq_s1  <= irq_src_i;
            irq_s2  <= irq_s1;
            irq_n_o <= ~|irq_pending_o;
            nmi_s1  <= nmi_src_i;
            nmi_s2  <= nmi_s1;
            nmi_s3  <= nmi_s2;
            // leaving the pulse always yields one high cycle before a queued NMI fires
            if (!nmi_n_o) begin
                nmi_pend <= nmi_pend | nmi_edge;
                if (pcnt == '0)
                    nmi_n_o <= 1'b1;
                else
                    pcnt <= pcnt - PW'(1);
            end else if (nmi_edge || nmi_pend) begin
                nmi_n_o  <= 1'b0;
                nmi_pend <= 1'b0;
                pcnt     <= PW'(NMI_PULSE - 1);
            end
        end
    end
endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// tb_cpu_bus_ctrl: directed scenarios with hand-computed expectations for cpu_bus_ctrl.
module tb_cpu_bus_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [15:0] cpu_a = '0, bus_a;
    logic [7:0]  cpu_d_w = '0, cpu_d_r, bus_d_w;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0, cpu_rdy;
    logic [63:0] region_base = {16'h6000, 16'h8000, 16'h2000, 16'h0000};
    logic [63:0] region_mask = {16'hE000, 16'h8000, 16'hE000, 16'hE000};
    logic [11:0] region_wait = {3'd1, 3'd7, 3'd3, 3'd0};
    logic [31:0] bus_d_r = {8'h3C, 8'hC3, 8'h5A, 8'h11};
    logic [3:0]  bus_sel, irq_src = '0, irq_en = '0, irq_pend;
    logic        bus_rd, bus_wr, irq_n, nmi_n;
    logic [1:0]  nmi_src = '0;
    int          nvec = 0, nerr = 0;

    cpu_bus_ctrl dut (
        .clk_clk_i(clk), .rst_rst_n_i(rst_n),
        .cpu_a_i(cpu_a), .cpu_d_i(cpu_d_w), .cpu_rd_i(cpu_rd), .cpu_wr_i(cpu_wr),
        .cpu_d_o(cpu_d_r), .cpu_rdy_o(cpu_rdy),
        .region_base_i(region_base), .region_mask_i(region_mask), .region_wait_i(region_wait),
        .bus_sel_o(bus_sel), .bus_a_o(bus_a), .bus_d_o(bus_d_w), .bus_rd_o(bus_rd), .bus_wr_o(bus_wr),
        .bus_d_i(bus_d_r),
        .irq_src_i(irq_src), .irq_en_i(irq_en), .nmi_src_i(nmi_src),
        .irq_n_o(irq_n), .nmi_n_o(nmi_n), .irq_pending_o(irq_pend)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drives one read and measures stall cycles and the data seen on the completing cycle
    task automatic run_read(input logic [15:0] a, output int lows, output logic [7:0] d);
        cpu_a  = a;
        cpu_rd = 1'b1;
        #1;
        lows = 0;
        while (!cpu_rdy && lows < 20) begin
            lows++;
            tick();
        end
        d = cpu_d_r;
        tick();
        cpu_rd = 1'b0;
    endtask

    task automatic test_reset();
        int l;
        logic [7:0] d;
        rst_n  = 1'b0;
        cpu_a  = 16'h2002;
        cpu_rd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (cpu_rdy !== 1'b1) begin nerr++; $display("FAIL reset_rdy: got %b want 1", cpu_rdy); end
        nvec++; if (irq_n !== 1'b1) begin nerr++; $display("FAIL reset_irq_n: got %b want 1", irq_n); end
        nvec++; if (nmi_n !== 1'b1) begin nerr++; $display("FAIL reset_nmi_n: got %b want 1", nmi_n); end
        nvec++; if (irq_pend !== 4'b0000) begin nerr++; $display("FAIL reset_irq_pending: got %b want 0000", irq_pend); end
        cpu_rd = 1'b0;
        rst_n  = 1'b1;
        tick();
        cpu_a  = 16'h5000;
        cpu_rd = 1'b1;
        #1;
        nvec++; if (bus_sel !== 4'b0000) begin nerr++; $display("FAIL unmapped_sel: got %b want 0000", bus_sel); end
        nvec++; if (bus_rd !== 1'b0) begin nerr++; $display("FAIL unmapped_bus_rd: got %b want 0", bus_rd); end
        run_read(16'h5000, l, d);
        nvec++; if (l !== 0) begin nerr++; $display("FAIL openbus_reset_lat: got %0d want 0", l); end
        nvec++; if (d !== 8'h00) begin nerr++; $display("FAIL openbus_reset_data: got %h want 00", d); end
    endtask

    task automatic test_waited_read();
        int l = 0;
        cpu_a  = 16'h2002;
        cpu_rd = 1'b1;
        #1;
        nvec++; if (bus_sel !== 4'b0010) begin nerr++; $display("FAIL wread_sel: got %b want 0010", bus_sel); end
        nvec++; if (bus_rd !== 1'b1) begin nerr++; $display("FAIL wread_bus_rd: got %b want 1", bus_rd); end
        while (!cpu_rdy && l < 20) begin
            l++;
            tick();
        end
        nvec++; if (l !== 3) begin nerr++; $display("FAIL wread_stall: got %0d want 3", l); end
        nvec++; if (cpu_d_r !== 8'h5A) begin nerr++; $display("FAIL wread_data: got %h want 5a", cpu_d_r); end
        tick();
        cpu_rd = 1'b0;
    endtask

    task automatic test_write();
        cpu_a   = 16'h2002;
        cpu_d_w = 8'h77;
        cpu_wr  = 1'b1;
        #1;
        nvec++; if (bus_wr !== 1'b1) begin nerr++; $display("FAIL write_strobe: got %b want 1", bus_wr); end
        nvec++; if (bus_sel !== 4'b0010) begin nerr++; $display("FAIL write_sel: got %b want 0010", bus_sel); end
        nvec++; if (bus_d_w !== 8'h77) begin nerr++; $display("FAIL write_data: got %h want 77", bus_d_w); end
        nvec++; if (bus_a !== 16'h2002) begin nerr++; $display("FAIL write_addr: got %h want 2002", bus_a); end
        nvec++; if (cpu_rdy !== 1'b1) begin nerr++; $display("FAIL write_rdy: got %b want 1", cpu_rdy); end
        tick();
        nvec++; if (cpu_rdy !== 1'b1) begin nerr++; $display("FAIL write_rdy_next: got %b want 1", cpu_rdy); end
        cpu_wr = 1'b0;
        #1;
        nvec++; if (bus_wr !== 1'b0) begin nerr++; $display("FAIL write_strobe_off: got %b want 0", bus_wr); end
    endtask

    task automatic test_open_bus();
        int l;
        logic [7:0] d;
        run_read(16'h2002, l, d);
        nvec++; if (d !== 8'h5A) begin nerr++; $display("FAIL ob_src_data: got %h want 5a", d); end
        run_read(16'h5000, l, d);
        nvec++; if (l !== 0) begin nerr++; $display("FAIL ob_lat: got %0d want 0", l); end
        nvec++; if (d !== 8'h5A) begin nerr++; $display("FAIL ob_data: got %h want 5a", d); end
        run_read(16'h0010, l, d);
        nvec++; if (l !== 0 || d !== 8'h11) begin nerr++; $display("FAIL zero_wait_read: got lat %0d data %h want 0 11", l, d); end
        run_read(16'h4FFF, l, d);
        nvec++; if (d !== 8'h11) begin nerr++; $display("FAIL ob_update: got %h want 11", d); end
    endtask

    task automatic test_priority();
        region_base[63:48] = 16'h0800;
        region_mask[63:48] = 16'hF800;
        cpu_a  = 16'h0800;
        cpu_rd = 1'b1;
        #1;
        nvec++; if (bus_sel !== 4'b0001) begin nerr++; $display("FAIL prio_sel: got %b want 0001", bus_sel); end
        nvec++; if (cpu_d_r !== 8'h11) begin nerr++; $display("FAIL prio_data: got %h want 11", cpu_d_r); end
        tick();
        cpu_rd = 1'b0;
        region_base[63:48] = 16'h6000;
        region_mask[63:48] = 16'hE000;
    endtask

    task automatic test_back_to_back();
        int l1, l2, l3;
        logic [7:0] d1, d2, d3;
        run_read(16'h2004, l1, d1);
        run_read(16'h6001, l2, d2);
        run_read(16'h2006, l3, d3);
        nvec++; if (l1 !== 3 || l2 !== 1 || l3 !== 3) begin nerr++; $display("FAIL b2b_stalls: got %0d %0d %0d want 3 1 3", l1, l2, l3); end
        nvec++; if (d2 !== 8'h3C) begin nerr++; $display("FAIL b2b_data: got %h want 3c", d2); end
    endtask

    task automatic test_abort();
        int l;
        logic [7:0] d;
        cpu_a  = 16'h8000;
        cpu_rd = 1'b1;
        #1;
        tick();
        tick();
        nvec++; if (cpu_rdy !== 1'b0) begin nerr++; $display("FAIL abort_stalled: got %b want 0", cpu_rdy); end
        cpu_rd = 1'b0;
        #1;
        nvec++; if (cpu_rdy !== 1'b1) begin nerr++; $display("FAIL abort_rdy: got %b want 1", cpu_rdy); end
        tick();
        run_read(16'h2002, l, d);
        nvec++; if (l !== 3) begin nerr++; $display("FAIL abort_next_stall: got %0d want 3", l); end
    endtask

    task automatic test_irq_mask();
        irq_en  = 4'b1011;
        irq_src = 4'b0100;
        repeat (4) tick();
        nvec++; if (irq_pend !== 4'b0000) begin nerr++; $display("FAIL irq_masked_pend: got %b want 0000", irq_pend); end
        nvec++; if (irq_n !== 1'b1) begin nerr++; $display("FAIL irq_masked: got %b want 1", irq_n); end
        irq_en = 4'b1111;
        #1;
        nvec++; if (irq_pend !== 4'b0100) begin nerr++; $display("FAIL irq_pend: got %b want 0100", irq_pend); end
        tick();
        nvec++; if (irq_n !== 1'b0) begin nerr++; $display("FAIL irq_unmask: got %b want 0", irq_n); end
        irq_src = 4'b0000;
        tick();
        tick();
        nvec++; if (irq_n !== 1'b0) begin nerr++; $display("FAIL irq_release_early: got %b want 0", irq_n); end
        tick();
        nvec++; if (irq_n !== 1'b1) begin nerr++; $display("FAIL irq_release: got %b want 1", irq_n); end
        irq_src = 4'b0001;
        tick();
        tick();
        nvec++; if (irq_n !== 1'b1) begin nerr++; $display("FAIL irq_rise_early: got %b want 1", irq_n); end
        tick();
        nvec++; if (irq_n !== 1'b0) begin nerr++; $display("FAIL irq_rise: got %b want 0", irq_n); end
        irq_src = 4'b0000;
        repeat (4) tick();
    endtask

    task automatic test_nmi_queue();
        logic [1:10] exp_seq = 10'b1100100111;
        nmi_src = 2'b01;
        for (int i = 1; i <= 10; i++) begin
            tick();
            nvec++; if (nmi_n !== exp_seq[i]) begin nerr++; $display("FAIL nmi_seq[%0d]: got %b want %b", i, nmi_n, exp_seq[i]); end
            if (i == 1) nmi_src = 2'b10;
            if (i == 2) nmi_src = 2'b11;
        end
        nmi_src = 2'b00;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid_stall();
        int l;
        logic [7:0] d;
        irq_en  = 4'b1111;
        irq_src = 4'b0001;
        nmi_src = 2'b01;
        repeat (3) tick();
        nvec++; if (irq_n !== 1'b0 || nmi_n !== 1'b0) begin nerr++; $display("FAIL pre_reset_int: got irq_n %b nmi_n %b want 0 0", irq_n, nmi_n); end
        cpu_a  = 16'h8000;
        cpu_rd = 1'b1;
        #1;
        tick();
        nvec++; if (cpu_rdy !== 1'b0) begin nerr++; $display("FAIL w7_stalled: got %b want 0", cpu_rdy); end
        rst_n = 1'b0;
        #1;
        nvec++; if (cpu_rdy !== 1'b1) begin nerr++; $display("FAIL midreset_rdy: got %b want 1", cpu_rdy); end
        nvec++; if (irq_n !== 1'b1 || nmi_n !== 1'b1) begin nerr++; $display("FAIL midreset_int: got irq_n %b nmi_n %b want 1 1", irq_n, nmi_n); end
        irq_src = 4'b0000;
        nmi_src = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;
        run_read(16'h8000, l, d);
        nvec++; if (l !== 7) begin nerr++; $display("FAIL w7_stall: got %0d want 7", l); end
        nvec++; if (d !== 8'hC3) begin nerr++; $display("FAIL w7_data: got %h want c3", d); end
    endtask

    initial begin
        test_reset();
        test_waited_read();
        test_write();
        test_open_bus();
        test_priority();
        test_back_to_back();
        test_abort();
        test_irq_mask();
        test_nmi_queue();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/cpu_bus_ctrl.md
# cpu_bus_ctrl

Parametrised bus controller between the 6502 `Core` and the NES memory map. It decodes CPU addresses into N configurable slave regions and inserts per-region read wait states by deasserting RDY. It returns open-bus data for unmapped reads. It also aggregates and synchronises multiple IRQ and NMI sources into the core's active-low interrupt inputs, giving the CPU wrapper generality in region count, wait states and interrupt channels that it lacks today.

## Interface
- `ADDR_W`, 16: CPU address width.
- `DATA_W`, 8: data width.
- `N_REGIONS`, 4: number of decoded slave regions.
- `WAIT_W`, 3: width of each per-region wait-state count.
- `N_IRQ`, 4: number of level-sensitive IRQ sources.
- `N_NMI`, 2: number of edge-sensitive NMI sources.
- `NMI_PULSE`, 2: cycles `nmi_n_o` is held low per NMI (≥1).
- `clk_clk_i` in 1: system clock. One clock only.
- `rst_rst_n_i` in 1: reset. Asynchronous, active-low.
- `cpu_a_i` in ADDR_W: CPU address (`a_o` of core).
- `cpu_d_i` in DATA_W: CPU write data (`d_o` of core).
- `cpu_rd_i` in 1: read strobe.
- `cpu_wr_i` in 1: write strobe.
- `cpu_d_o` out DATA_W: read data to the core (`d_i`).
- `cpu_rdy_o` out 1: to the core's `rdy_i`.
- `region_base_i` in N_REGIONS*ADDR_W: base address for each region.
- `region_mask_i` in N_REGIONS*ADDR_W: compare mask for each region.
- `region_wait_i` in N_REGIONS*WAIT_W: read wait states for each region.
- `bus_sel_o` out N_REGIONS: one-hot slave select. All zero when no region hits.
- `bus_a_o` out ADDR_W: slave address, equal to `cpu_a_i`.
- `bus_d_o` out DATA_W: slave write data, equal to `cpu_d_i`.
- `bus_rd_o` out 1: slave read strobe.
- `bus_wr_o` out 1: slave write strobe.
- `bus_d_i` in N_REGIONS*DATA_W: read data from each slave.
- `irq_src_i` in N_IRQ: asynchronous level IRQ requests, active-high.
- `irq_en_i` in N_IRQ: IRQ enable mask.
- `nmi_src_i` in N_NMI: asynchronous NMI requests. Rising edge triggers.
- `irq_n_o` out 1: to the core's `irq_n_i`.
- `nmi_n_o` out 1: to the core's `nmi_n_i`.
- `irq_pending_o` out N_IRQ: synchronised and masked IRQ status.

## Operation
- **Decode.** Region k hits when `(cpu_a_i & mask_k) == (base_k & mask_k)`. If several regions hit, the lowest index wins. `bus_sel_o` is combinational. Strobes pass through, gated to 0 when no region hits.
- **Writes.** Writes complete in one cycle and never stall. `cpu_rdy_o` stays 1.
- **Wait FSM, IDLE.** `cpu_rdy_o` = 1 unless `cpu_rd_i` targets a hit region with wait w > 0. In that case `cpu_rdy_o` = 0 combinationally, cnt ← w−1, and the FSM goes to WAIT.
- **Wait FSM, WAIT.** While cnt ≠ 0: `cpu_rdy_o` = 0 and cnt decrements. When cnt = 0: `cpu_rdy_o` = 1, the access completes, and the FSM returns to IDLE.
- **Wait FSM, exit.** If `cpu_rd_i` drops while in WAIT, the FSM returns to IDLE at once with `cpu_rdy_o` = 1.
- **Read data.** `cpu_d_o` is the selected slave's `bus_d_i` slice. On every completing read to a hit region, that value is latched into the open-bus register.
- **Open bus.** A read with no region hit completes in 1 cycle. `cpu_d_o` returns the open-bus register.
- **IRQ path.** Each `irq_src_i` bit passes a 2-flop synchroniser. `irq_pending_o` = synchronised & `irq_en_i`. `irq_n_o` is registered: `~|irq_pending_o`.
- **NMI path.** Each `nmi_src_i` bit passes a 2-flop synchroniser plus an edge-detect flop. A rising edge on any source drives `nmi_n_o` low for NMI_PULSE cycles.
- **NMI during a pulse.** An edge that arrives while a pulse is active, or in the mandatory 1-cycle high gap after it, sets a single pending flag. The pending NMI issues after the gap. Further edges while the flag is set are merged into it.

## Timing
- **Reset values.** FSM = IDLE, cnt = 0, open-bus register = 0, `irq_n_o` = 1, `nmi_n_o` = 1. `irq_pending_o` = 0 and `cpu_rdy_o` = 1.
- **Reset mid-WAIT.** The stall aborts immediately. `cpu_rdy_o` = 1 asynchronously.
- **Read latency.** w+1 cycles for a region with wait w: exactly w consecutive cycles with `cpu_rdy_o` = 0, then one completing cycle.
- **Back-to-back reads.** Consecutive stalled reads each stall the full w cycles. There are no idle cycles between them.
- **IRQ latency.** A source rising at edge 0 gives `irq_n_o` low after edge 3. Release has the same latency.
- **IRQ mask.** Clearing an `irq_en_i` bit affects `irq_n_o` after 1 edge.
- **NMI latency.** A source rising at edge 0 gives `nmi_n_o` low after edge 3, held for NMI_PULSE edges.
- **NMI spacing.** Minimum spacing between NMI pulses is NMI_PULSE+1 cycles.
- **Counter width.** cnt is WAIT_W bits. w = 2^WAIT_W−1 must work without wrap.

## Test plan
- **Waited read.** Region 1 = base 0x2000, mask 0xE000, wait 3. Read at 0x2002 -> `cpu_rdy_o` low for exactly 3 cycles, `bus_sel_o` = 0b0010, `cpu_d_o` = `bus_d_i`[1] = 0x5A on the 4th cycle.
- **Waited write.** Write 0x77 to 0x2002 -> `bus_wr_o` = 1 for 1 cycle, `cpu_rdy_o` never low, `bus_d_o` = 0x77.
- **Open bus.** Read 0x2002 (data 0x5A), then read unmapped 0x5000 -> 1-cycle completion, `cpu_d_o` = 0x5A. Immediately after reset, the same unmapped read returns 0x00.
- **IRQ masking.** `irq_src_i` = 0b0100 with `irq_en_i` = 0b1011 -> `irq_n_o` stays 1. Set `irq_en_i` = 0b1111 -> `irq_n_o` = 0 after 1 cycle. Drop the source -> `irq_n_o` = 1 after 3 cycles.
- **NMI queuing.** NMI_PULSE = 2. Rising edges on `nmi_src_i`[0] and then `nmi_src_i`[1`] one cycle apart -> two distinct 2-cycle low pulses on `nmi_n_o`, separated by exactly 1 high cycle. A third edge during the pulses merges into the pending NMI.
- **Reset mid-stall.** Assert `rst_rst_n_i` during cycle 2 of a wait-7 read -> `cpu_rdy_o` = 1, `nmi_n_o` = `irq_n_o` = 1, FSM = IDLE. The next read stalls the full 7 cycles.
